trap_ctrl: RTL and testbench
============================

TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 The block SHALL have parameter ACK_TIMEOUT, default 15, the maximum number of cycles spent in WAIT_ACK before abort.
REQ-002 The block SHALL have ports:
CLK  in  1  system clock; all state changes on rising edge.
RESET  in  1  synchronous, active-high reset.
EXC_VALID  in  1  synchronous exception request from pipeline.
EXC_CODE  in  5  exception cause code.
EXC_NPC  in  64  PC to save for an exception.
INT_PEND  in  3  pending interrupts {MEI,MTI,MSI}, level.
INT_EN  in  3  per-interrupt enables, same order.
GIE  in  1  global interrupt enable (current status.xie).
RUN_NPC  in  64  next sequential PC, saved for interrupts.
PIPE_EMPTY  in  1  pipeline drained.
DE_CS  in  1  one-cycle context-switch-done pulse from the CSR file.
CS  out  1  context-switch strobe to the CSR file.
CAUSE  out  64  cause value to the CSR file.
NPC  out  64  PC to save in _PC.
STALL  out  1  freeze fetch/issue.
FLUSH  out  1  kill in-flight instructions.
BUSY  out  1  state is not IDLE.
TIMEOUT  out  1  sticky; set when DE_CS never arrives.
REQ-003 Reset is synchronous and active-high on RESET; one clock, CLK.

Function
REQ-004 FSM states SHALL be IDLE, DRAIN, SWITCH and WAIT_ACK; all outputs SHALL be registered.
REQ-005 In IDLE, EXC_VALID=1 SHALL win: CAUSE<={59'b0,EXC_CODE}, NPC<=EXC_NPC, next state DRAIN.
REQ-006 In IDLE, with no exception and GIE=1 and (INT_PEND&INT_EN)!=0, the block SHALL select by priority MEI>MSI>MTI: CAUSE<={1'b1,52'b0,11'(code)} with code 11/3/7, NPC<=RUN_NPC, next state DRAIN.
REQ-007 With GIE=0, interrupts SHALL be ignored; exceptions SHALL still be taken.
REQ-008 FLUSH SHALL be 1 for exactly the first cycle in DRAIN; STALL SHALL be 1 in DRAIN, SWITCH and WAIT_ACK.
REQ-009 DRAIN SHALL go to SWITCH on the first cycle with PIPE_EMPTY=1, which may be the entry cycle.
REQ-010 SWITCH SHALL last one cycle with CS=1; CS SHALL be 0 in every other state; next state WAIT_ACK.
REQ-011 Minimum latency: a request sampled in IDLE at edge t gives FLUSH in cycle t+1 and CS in cycle t+2.
REQ-012 CAUSE and NPC SHALL hold their captured values from DRAIN entry until the next capture.
REQ-013 WAIT_ACK SHALL go to IDLE on DE_CS=1 and clear the timeout counter.
REQ-014 The timeout counter SHALL count WAIT_ACK cycles; at ACK_TIMEOUT with no DE_CS, the block SHALL set TIMEOUT and go to IDLE.
REQ-015 DE_CS seen outside WAIT_ACK SHALL be ignored.
REQ-016 EXC_VALID while BUSY=1 SHALL be dropped; interrupt lines are level and SHALL be re-evaluated in IDLE.
REQ-017 After returning from WAIT_ACK, IDLE SHALL last at least one cycle before a new capture.
REQ-018 BUSY SHALL be 1 in every state except IDLE.

Reset
REQ-019 RESET=1 SHALL force IDLE in any state, including mid-DRAIN or WAIT_ACK, and discard the in-progress request.
REQ-020 RESET=1 SHALL clear CS, STALL, FLUSH, BUSY, TIMEOUT, CAUSE, NPC and the timeout counter to 0.
REQ-021 TIMEOUT SHALL clear only on reset.

Structure
REQ-022 Shared package trap_pkg SHALL hold:
- the state encoding;
- interrupt cause codes MEI=11, MSI=3, MTI=7;
- INT_PEND bit indices;
- the cause interrupt-bit position, 63.
REQ-023 The priority selection SHALL be a combinational sub-module, trap_prio_enc, with inputs pend&en and outputs valid and code.

Verification
REQ-024 The bench SHALL cover these scenarios:
- Exception: EXC_VALID=1, EXC_CODE=2, EXC_NPC=0x1000, PIPE_EMPTY=1 -> FLUSH at t+1, CS pulse at t+2, CAUSE=0x2, NPC=0x1000; DE_CS at t+4 -> IDLE at t+5, STALL low.
- Priority: INT_PEND=3'b111, INT_EN=3'b111, GIE=1, EXC_VALID=0 -> CAUSE=0x800000000000000B; with EXC_VALID=1 and code 8 in the same cycle -> CAUSE=0x8.
- Masking: GIE=0, INT_PEND=3'b010, INT_EN=3'b010 -> stays IDLE, CS never 1; then GIE=1 -> CAUSE=0x8000000000000007.
- Drain: PIPE_EMPTY held 0 for 5 cycles after the request -> STALL high, FLUSH high one cycle only, CS only after PIPE_EMPTY=1.
- Timeout: no DE_CS after CS -> TIMEOUT=1 and IDLE exactly 15 cycles into WAIT_ACK; a later request still completes normally.
- Reset: RESET=1 in WAIT_ACK -> next cycle IDLE with all outputs 0; a stale DE_CS afterwards is ignored.

Source files
------------

// File: rtl/trap_pkg.sv
// Shared definitions for the trap controller: FSM states, interrupt cause codes,
// interrupt line positions and the cause-register layout.
package trap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_SWITCH   = 2'd2,
        ST_WAIT_ACK = 2'd3
    } trap_state_e;

    localparam int CODE_W = 5;

    localparam logic [CODE_W-1:0] CODE_MEI = 5'd11;
    localparam logic [CODE_W-1:0] CODE_MSI = 5'd3;
    localparam logic [CODE_W-1:0] CODE_MTI = 5'd7;

    // INT_PEND / INT_EN are ordered {MEI, MTI, MSI}
    localparam int IRQ_MSI = 0;
    localparam int IRQ_MTI = 1;
    localparam int IRQ_MEI = 2;

    localparam int CAUSE_INT_BIT = 63;

    function automatic logic [63:0] int_cause(input logic [CODE_W-1:0] code);
        logic [63:0] c;
        c                = 64'(code);
        c[CAUSE_INT_BIT] = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/trap_prio_enc.sv
// Fixed-priority interrupt selector: MEI beats MSI beats MTI.
module trap_prio_enc
    import trap_pkg::*;
(
    input  logic [2:0]        pend_en,
    output logic              valid,
    output logic [CODE_W-1:0] code
);

    always_comb begin
        valid = |pend_en;
        code  = '0;
        if (pend_en[IRQ_MEI]) begin
            code = CODE_MEI;
        end else if (pend_en[IRQ_MSI]) begin
            code = CODE_MSI;
        end else if (pend_en[IRQ_MTI]) begin
            code = CODE_MTI;
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Trap sequencer: captures an exception or interrupt, drains the pipeline,
// strobes the CSR context switch and waits (bounded) for its acknowledge.
module trap_ctrl
    import trap_pkg::*;
#(
    parameter int ACK_TIMEOUT = 15
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        EXC_VALID,
    input  logic [4:0]  EXC_CODE,
    input  logic [63:0] EXC_NPC,
    input  logic [2:0]  INT_PEND,
    input  logic [2:0]  INT_EN,
    input  logic        GIE,
    input  logic [63:0] RUN_NPC,
    input  logic        PIPE_EMPTY,
    input  logic        DE_CS,
    output logic        CS,
    output logic [63:0] CAUSE,
    output logic [63:0] NPC,
    output logic        STALL,
    output logic        FLUSH,
    output logic        BUSY,
    output logic        TIMEOUT
);

    localparam int                CNT_W    = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    trap_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [63:0]       cause_q, cause_d;
    logic [63:0]       npc_q, npc_d;
    logic              cs_q, cs_d;
    logic              stall_q, stall_d;
    logic              flush_q, flush_d;
    logic              busy_q, busy_d;
    logic              timeout_q, timeout_d;

    logic              irq_valid;
    logic [CODE_W-1:0] irq_code;

    trap_prio_enc u_prio (
        .pend_en (INT_PEND & INT_EN),
        .valid   (irq_valid),
        .code    (irq_code)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cause_d   = cause_q;
        npc_d     = npc_q;
        timeout_d = timeout_q;

        case (state_q)
            ST_IDLE: begin
                if (EXC_VALID) begin
                    cause_d = {59'b0, EXC_CODE};
                    npc_d   = EXC_NPC;
                    state_d = ST_DRAIN;
                end else if (GIE && irq_valid) begin
                    cause_d = int_cause(irq_code);
                    npc_d   = RUN_NPC;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (PIPE_EMPTY) begin
                    state_d = ST_SWITCH;
                end
            end
            ST_SWITCH: begin
                cnt_d   = '0;
                state_d = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                // An acknowledge on the final allowed cycle still counts as in time
                if (DE_CS) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they line up with it once registered
        flush_d = (state_q == ST_IDLE) && (state_d == ST_DRAIN);
        cs_d    = (state_d == ST_SWITCH);
        stall_d = (state_d != ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            cause_q   <= '0;
            npc_q     <= '0;
            cs_q      <= 1'b0;
            stall_q   <= 1'b0;
            flush_q   <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cause_q   <= cause_d;
            npc_q     <= npc_d;
            cs_q      <= cs_d;
            stall_q   <= stall_d;
            flush_q   <= flush_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    assign CS      = cs_q;
    assign CAUSE   = cause_q;
    assign NPC     = npc_q;
    assign STALL   = stall_q;
    assign FLUSH   = flush_q;
    assign BUSY    = busy_q;
    assign TIMEOUT = timeout_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed scenarios plus randomized
// transactions compared against a transaction-level reference model.
module tb_trap_ctrl;

    localparam int ACK_TO = 15;
    localparam int PRIO_BIT  [3] = '{2, 0, 1};
    localparam int PRIO_CODE [3] = '{11, 3, 7};

    logic        clk = 1'b0;
    logic        reset;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [63:0] exc_npc;
    logic [2:0]  int_pend;
    logic [2:0]  int_en;
    logic        gie;
    logic [63:0] run_npc;
    logic        pipe_empty;
    logic        de_cs;
    logic        cs;
    logic [63:0] cause;
    logic [63:0] npc;
    logic        stall;
    logic        flush;
    logic        busy;
    logic        timeout;

    int          err_cnt = 0;
    int          chk_cnt = 0;
    int          txn_cnt = 0;

    logic [63:0] m_cause = 64'd0;
    logic [63:0] m_npc   = 64'd0;
    bit          m_to    = 1'b0;

    trap_ctrl #(.ACK_TIMEOUT(ACK_TO)) dut (
        .CLK        (clk),
        .RESET      (reset),
        .EXC_VALID  (exc_valid),
        .EXC_CODE   (exc_code),
        .EXC_NPC    (exc_npc),
        .INT_PEND   (int_pend),
        .INT_EN     (int_en),
        .GIE        (gie),
        .RUN_NPC    (run_npc),
        .PIPE_EMPTY (pipe_empty),
        .DE_CS      (de_cs),
        .CS         (cs),
        .CAUSE      (cause),
        .NPC        (npc),
        .STALL      (stall),
        .FLUSH      (flush),
        .BUSY       (busy),
        .TIMEOUT    (timeout)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (txn %0d, t=%0t)", tag, got, exp, txn_cnt, $time);
        end
    endtask

    function automatic logic [63:0] model_cause(input bit ev, input logic [4:0] code,
                                                input logic [2:0] pend, input logic [2:0] en);
        if (ev) return 64'(code);
        for (int i = 0; i < 3; i++) begin
            if (pend[PRIO_BIT[i]] && en[PRIO_BIT[i]])
                return 64'h8000_0000_0000_0000 + 64'(PRIO_CODE[i]);
        end
        return 64'd0;
    endfunction

    task automatic check_all_idle(input string tag);
        check_val({tag, "_busy"},  64'(busy),    64'd0);
        check_val({tag, "_stall"}, 64'(stall),   64'd0);
        check_val({tag, "_flush"}, 64'(flush),   64'd0);
        check_val({tag, "_cs"},    64'(cs),      64'd0);
        check_val({tag, "_to"},    64'(timeout), 64'(m_to));
        check_val({tag, "_cause"}, cause,        m_cause);
        check_val({tag, "_npc"},   npc,          m_npc);
    endtask

    // One full request from IDLE. ack_at: WAIT_ACK cycle (1..ACK_TO) carrying DE_CS, 0 = never.
    // rst_at: WAIT_ACK cycle in which RESET is applied instead, 0 = none.
    task automatic run_txn(input bit ev, input logic [4:0] code, input logic [63:0] enpc,
                           input logic [2:0] pend, input logic [2:0] en, input bit g,
                           input logic [63:0] rnpc, input int drain_wait, input int ack_at,
                           input int rst_at, input bit hold_int);
        bit taken;
        taken = ev || (g && ((pend & en) != 3'b000));
        txn_cnt++;
        check_val("pre_idle", 64'(busy), 64'd0);
        exc_valid  = ev;
        exc_code   = code;
        exc_npc    = enpc;
        int_pend   = pend;
        int_en     = en;
        gie        = g;
        run_npc    = rnpc;
        de_cs      = 1'b0;
        pipe_empty = 1'($urandom_range(0, 1));
        tick;
        exc_valid = 1'b0;
        exc_code  = 5'($urandom);
        exc_npc   = {$urandom, $urandom};
        run_npc   = {$urandom, $urandom};
        if (!hold_int) int_pend = 3'b000;
        if (!taken) begin
            check_all_idle("nocap");
            $display("txn %0d: not taken (ev=%0d pend=%b en=%b gie=%0d)", txn_cnt, ev, pend, en, g);
            return;
        end
        m_cause = model_cause(ev, code, pend, en);
        m_npc   = ev ? enpc : rnpc;
        check_val("flush_first", 64'(flush), 64'd1);
        check_val("stall_drain", 64'(stall), 64'd1);
        check_val("busy_drain",  64'(busy),  64'd1);
        check_val("cs_drain",    64'(cs),    64'd0);
        check_val("cause_cap",   cause,      m_cause);
        check_val("npc_cap",     npc,        m_npc);
        for (int i = 0; i < drain_wait; i++) begin
            pipe_empty = 1'b0;
            exc_valid  = 1'($urandom_range(0, 1));
            de_cs      = 1'($urandom_range(0, 1));
            tick;
            check_val("flush_once", 64'(flush), 64'd0);
            check_val("stall_hold", 64'(stall), 64'd1);
            check_val("cs_early",   64'(cs),    64'd0);
        end
        pipe_empty = 1'b1;
        exc_valid  = 1'($urandom_range(0, 1));
        de_cs      = 1'($urandom_range(0, 1));
        tick;
        check_val("cs_pulse",   64'(cs),    64'd1);
        check_val("flush_sw",   64'(flush), 64'd0);
        check_val("stall_sw",   64'(stall), 64'd1);
        check_val("cause_hold", cause,      m_cause);
        de_cs      = 1'($urandom_range(0, 1));
        pipe_empty = 1'($urandom_range(0, 1));
        tick;
        check_val("cs_end",   64'(cs),   64'd0);
        check_val("busy_wa",  64'(busy), 64'd1);
        check_val("stall_wa", 64'(stall), 64'd1);
        for (int j = 1; j <= ACK_TO; j++) begin
            exc_valid = 1'($urandom_range(0, 1));
            if (j == rst_at) begin
                reset = 1'b1;
                de_cs = 1'b0;
                tick;
                reset     = 1'b0;
                exc_valid = 1'b0;
                m_cause   = 64'd0;
                m_npc     = 64'd0;
                m_to      = 1'b0;
                check_all_idle("rst_wa");
                $display("txn %0d: reset in WAIT_ACK cycle %0d", txn_cnt, j);
                return;
            end
            de_cs = (j == ack_at);
            tick;
            de_cs = 1'b0;
            if (j == ack_at) begin
                check_val("busy_ack",  64'(busy),    64'd0);
                check_val("stall_ack", 64'(stall),   64'd0);
                check_val("to_ack",    64'(timeout), 64'(m_to));
                break;
            end else if (j == ACK_TO) begin
                m_to = 1'b1;
                check_val("busy_to", 64'(busy),    64'd0);
                check_val("to_set",  64'(timeout), 64'd1);
            end else begin
                check_val("busy_wait", 64'(busy),    64'd1);
                check_val("to_wait",   64'(timeout), 64'(m_to));
            end
        end
        exc_valid = 1'b0;
        check_val("cs_ret",    64'(cs), 64'd0);
        check_val("cause_ret", cause,   m_cause);
        check_val("npc_ret",   npc,     m_npc);
        $display("txn %0d: cause=0x%016h npc=0x%016h drain=%0d ack_at=%0d to=%0d",
                 txn_cnt, m_cause, m_npc, drain_wait, ack_at, m_to);
    endtask

    initial begin
        reset      = 1'b1;
        exc_valid  = 1'b0;
        exc_code   = 5'd0;
        exc_npc    = 64'd0;
        int_pend   = 3'b000;
        int_en     = 3'b000;
        gie        = 1'b0;
        run_npc    = 64'd0;
        pipe_empty = 1'b1;
        de_cs      = 1'b0;
        tick;
        tick;
        check_all_idle("reset");
        reset = 1'b0;

        // Exception, minimum latency, DE_CS in second WAIT_ACK cycle
        run_txn(1'b1, 5'd2, 64'h1000, 3'b000, 3'b000, 1'b0, 64'h2000, 0, 2, 0, 1'b0);
        check_val("exc_cause", cause, 64'h2);

        // Interrupt priority, then exception wins over interrupts
        run_txn(1'b0, 5'd0, 64'h0, 3'b111, 3'b111, 1'b1, 64'h3000, 0, 1, 0, 1'b0);
        check_val("prio_mei", cause, 64'h8000_0000_0000_000B);
        run_txn(1'b1, 5'd8, 64'h4000, 3'b111, 3'b111, 1'b1, 64'h5000, 0, 1, 0, 1'b0);
        check_val("exc_wins", cause, 64'h8);

        // Masked by GIE for several cycles, then enabled
        int_pend = 3'b010;
        int_en   = 3'b010;
        gie      = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick;
            check_val("mask_cs",   64'(cs),   64'd0);
            check_val("mask_busy", 64'(busy), 64'd0);
        end
        run_txn(1'b0, 5'd0, 64'h0, 3'b010, 3'b010, 1'b1, 64'h6000, 0, 3, 0, 1'b0);
        check_val("mti_cause", cause, 64'h8000_0000_0000_0007);

        // Long drain
        run_txn(1'b1, 5'd5, 64'h7000, 3'b000, 3'b000, 1'b0, 64'h0, 5, 4, 0, 1'b0);

        // Timeout, then normal completion
        run_txn(1'b1, 5'd9, 64'h8000, 3'b000, 3'b000, 1'b0, 64'h0, 0, 0, 0, 1'b0);
        run_txn(1'b1, 5'd1, 64'h9000, 3'b000, 3'b000, 1'b0, 64'h0, 1, 5, 0, 1'b0);
        check_val("to_sticky", 64'(timeout), 64'd1);

        // Level interrupt held across return: IDLE lasts one cycle, then recaptured
        run_txn(1'b0, 5'd0, 64'h0, 3'b001, 3'b001, 1'b1, 64'hA000, 0, 2, 0, 1'b1);
        run_txn(1'b0, 5'd0, 64'h0, 3'b001, 3'b001, 1'b1, 64'hB000, 0, 2, 0, 1'b0);
        check_val("msi_cause", cause, 64'h8000_0000_0000_0003);

        // Reset mid-WAIT_ACK, stale DE_CS ignored, counter starts fresh
        run_txn(1'b1, 5'd3, 64'hC000, 3'b000, 3'b000, 1'b0, 64'h0, 0, 0, 10, 1'b0);
        de_cs = 1'b1;
        tick;
        de_cs = 1'b0;
        check_val("stale_busy", 64'(busy), 64'd0);
        check_val("stale_cs",   64'(cs),   64'd0);
        tick;
        check_val("stale_busy2", 64'(busy), 64'd0);
        run_txn(1'b1, 5'd4, 64'hD000, 3'b000, 3'b000, 1'b0, 64'h0, 0, 0, 0, 1'b0);

        // Randomized transactions
        for (int n = 0; n < 150; n++) begin
            bit          r_ev;
            logic [2:0]  r_pend, r_en;
            int          r_ack, r_rst;
            r_ev   = ($urandom_range(0, 2) == 0);
            r_pend = 3'($urandom);
            r_en   = 3'($urandom);
            r_ack  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, ACK_TO);
            r_rst  = ($urandom_range(0, 15) == 0) ? $urandom_range(1, ACK_TO) : 0;
            run_txn(r_ev, 5'($urandom), {$urandom, $urandom}, r_pend, r_en,
                    1'($urandom_range(0, 1)), {$urandom, $urandom},
                    $urandom_range(0, 4), r_ack, r_rst, 1'b0);
            for (int k = 0; k < $urandom_range(0, 2); k++) begin
                de_cs = 1'($urandom_range(0, 1));
                tick;
                de_cs = 1'b0;
                check_val("gap_busy", 64'(busy),    64'd0);
                check_val("gap_to",   64'(timeout), 64'(m_to));
            end
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
